// File: rtl/display_owner_arbiter.sv
// display_owner_arbiter: hands the board display (LEDR, HEX5..HEX0) to lab
// design A or B. Every owner change passes through a fixed blank interval,
// so segments from the two designs never mix on the display.
// The display pins are driven from registers.
// Optional feature: define DISPLAY_ARB_KEY_TOGGLE_EN to add a debounced
// KEY[1] press that flips the owner chosen by SW[9].
module display_owner_arbiter #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLANK_CYCLES    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel_sw,
  input  logic        key_n,
  input  logic [9:0]  leds_a,
  input  logic [47:0] hex_a,
  input  logic [9:0]  leds_b,
  input  logic [47:0] hex_b,
  output logic [9:0]  LEDR,
  output logic [47:0] HEX,
  output logic        owner,
  output logic        switching
);

  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [47:0]   HEX_OFF    = {6{8'hFF}};

  typedef enum logic [1:0] {BLANK, OWN_A, OWN_B} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] blank_cnt;
  logic          sel_meta, sel_sync;
  logic          req;

  // Two-flop synchronizer for the owner-select switch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_meta <= 1'b0;
      sel_sync <= 1'b0;
    end else begin
      sel_meta <= sel_sw;
      sel_sync <= sel_meta;
    end
  end

`ifdef DISPLAY_ARB_KEY_TOGGLE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          key_meta, key_sync, key_acc, toggle_flag, press;
  logic [DW-1:0] db_cnt;

  // Press pulse: the accepted level is about to fall from 1 to 0 this cycle
  always_comb begin
    press = (key_sync != key_acc) && (db_cnt == DB_LAST) && !key_sync;
  end

  // Key synchronizer, debounce counter, accepted level and toggle flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta    <= 1'b1;
      key_sync    <= 1'b1;
      key_acc     <= 1'b1;
      db_cnt      <= '0;
      toggle_flag <= 1'b0;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
      if (key_sync == key_acc) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_acc <= key_sync;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
      if (press) toggle_flag <= ~toggle_flag;
    end
  end

  assign req = sel_sync ^ toggle_flag;
`else
  // The key input and debounce length have no function in this build
  logic unused_key;
  assign unused_key = key_n ^ (DEBOUNCE_CYCLES == 0);
  assign req        = sel_sync;
`endif

  // Next-state decode; req is sampled when the blank interval runs out
  always_comb begin
    state_nxt = state;
    case (state)
      OWN_A:   if (req)  state_nxt = BLANK;
      OWN_B:   if (!req) state_nxt = BLANK;
      BLANK:   if (blank_cnt == '0) state_nxt = req ? OWN_B : OWN_A;
      default: state_nxt = BLANK;
    endcase
  end

  // State, blank counter and display registers, all loaded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BLANK;
      blank_cnt <= BLANK_LAST;
      owner     <= 1'b0;
      switching <= 1'b1;
      LEDR      <= '0;
      HEX       <= HEX_OFF;
    end else begin
      state <= state_nxt;
      if (state != BLANK && state_nxt == BLANK)
        blank_cnt <= BLANK_LAST;
      else if (state == BLANK && blank_cnt != '0)
        blank_cnt <= blank_cnt - BW'(1);
      case (state_nxt)
        OWN_A: begin
          LEDR      <= leds_a;
          HEX       <= hex_a;
          owner     <= 1'b0;
          switching <= 1'b0;
        end
        OWN_B: begin
          LEDR      <= leds_b;
          HEX       <= hex_b;
          owner     <= 1'b1;
          switching <= 1'b0;
        end
        default: begin
          LEDR      <= '0;
          HEX       <= HEX_OFF;
          switching <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_owner_arbiter.sv
// Bench for display_owner_arbiter (DEBOUNCE_CYCLES=8, BLANK_CYCLES=4).
// Key-toggle sequences run when DISPLAY_ARB_KEY_TOGGLE_EN is defined;
// otherwise the key-ignored sequence runs.
module tb_display_owner_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel_sw;
  logic        key_n;
  logic [9:0]  leds_a, leds_b;
  logic [47:0] hex_a, hex_b;
  logic [9:0]  LEDR;
  logic [47:0] HEX;
  logic        owner, switching;

  display_owner_arbiter #(.DEBOUNCE_CYCLES(8), .BLANK_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sel_sw(sel_sw), .key_n(key_n),
    .leds_a(leds_a), .hex_a(hex_a), .leds_b(leds_b), .hex_b(hex_b),
    .LEDR(LEDR), .HEX(HEX), .owner(owner), .switching(switching)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  leds;
    logic [47:0] hex;
    logic        own;
    logic        sw;
  } exp_t;

  typedef struct {
    logic [9:0]  la;
    logic [47:0] ha;
    logic [9:0]  lb;
    logic [47:0] hb;
    logic [9:0]  el;
    logic [47:0] eh;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[6];
  int   total = 0;
  int   passed = 0;

  task automatic cmp(input string tag, input string fld, input logic [47:0] act, input logic [47:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s.%s got %h want %h", tag, fld, act, want);
  endtask

  task automatic push_exp(input logic [9:0] l, input logic [47:0] h, input logic o, input logic s);
    exp_t e;
    e.leds = l; e.hex = h; e.own = o; e.sw = s;
    sbq.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      $display("FAIL %s scoreboard empty got none want entry", tag);
    end else begin
      e = sbq.pop_front();
      cmp(tag, "LEDR", {38'd0, LEDR}, {38'd0, e.leds});
      cmp(tag, "HEX", HEX, e.hex);
      cmp(tag, "owner", {47'd0, owner}, {47'd0, e.own});
      cmp(tag, "switching", {47'd0, switching}, {47'd0, e.sw});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_blank(input logic o, input string tag);
    push_exp(10'h000, 48'hFFFF_FFFF_FFFF, o, 1'b1);
    tick();
    check_out(tag);
  endtask

  task automatic step_a(input string tag);
    push_exp(leds_a, hex_a, 1'b0, 1'b0);
    tick();
    check_out(tag);
  endtask

  task automatic step_b(input string tag);
    push_exp(leds_b, hex_b, 1'b1, 1'b0);
    tick();
    check_out(tag);
  endtask

  task automatic step_own(input logic o, input string tag);
    if (o) step_b(tag);
    else   step_a(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic cur_own;
    vt[0] = '{10'h3FF, 48'h000000000000, 10'h155, 48'hFFFFFFFFFFFF, 10'h3FF, 48'h000000000000};
    vt[1] = '{10'h000, 48'hFFFFFFFFFFFF, 10'h155, 48'h000000000000, 10'h000, 48'hFFFFFFFFFFFF};
    vt[2] = '{10'h001, 48'h0123456789AB, 10'h3FF, 48'h000000000000, 10'h001, 48'h0123456789AB};
    vt[3] = '{10'h200, 48'h800000000001, 10'h3FF, 48'h111111111111, 10'h200, 48'h800000000001};
    vt[4] = '{10'h155, 48'h555555555555, 10'h2AA, 48'hAAAAAAAAAAAA, 10'h155, 48'h555555555555};
    vt[5] = '{10'h2AA, 48'hC0F9A4B09992, 10'h155, 48'h123456ABCDEF, 10'h2AA, 48'hC0F9A4B09992};

    rst_n  = 1'b0;
    sel_sw = 1'b0;
    key_n  = 1'b1;
    leds_a = 10'h2AA;
    hex_a  = 48'hC0F9A4B09992;
    leds_b = 10'h155;
    hex_b  = 48'h123456ABCDEF;

    // Reset state and the reset blank interval
    tick();
    tick();
    push_exp(10'h000, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b1);
    check_out("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step_blank(1'b0, "post_reset_blank");
    step_a("first_owner_a");

    // One-cycle latency while owning A; B images are ignored
    for (int i = 0; i < 6; i++) begin
      leds_a = vt[i].la; hex_a = vt[i].ha;
      leds_b = vt[i].lb; hex_b = vt[i].hb;
      push_exp(vt[i].el, vt[i].eh, 1'b0, 1'b0);
      tick();
      check_out($sformatf("vec%0d", i));
    end

    // A -> B: blank from edge 3, B data at edge 7
    sel_sw = 1'b1;
    step_a("a2b_e1");
    step_a("a2b_e2");
    for (int i = 0; i < 4; i++) step_blank(1'b0, "a2b_blank");
    step_b("a2b_e7");

    // B -> A
    sel_sw = 1'b0;
    step_b("b2a_e1");
    step_b("b2a_e2");
    for (int i = 0; i < 4; i++) step_blank(1'b1, "b2a_blank");
    step_a("b2a_e7");

    // Request withdrawn during BLANK: full interval, then back to A
    sel_sw = 1'b1;
    step_a("back_e1");
    step_a("back_e2");
    step_blank(1'b0, "back_blank");
    sel_sw = 1'b0;
    for (int i = 0; i < 3; i++) step_blank(1'b0, "back_blank");
    step_a("back_e7");
    step_a("back_hold");
    step_a("back_hold");

`ifdef DISPLAY_ARB_KEY_TOGGLE_EN
    // Bounce shorter than the debounce length does nothing
    key_n = 1'b0;
    for (int i = 0; i < 5; i++) step_a("bounce");
    key_n = 1'b1;
    for (int i = 0; i < 12; i++) step_a("bounce_quiet");

    // Held press: BLANK at edge 11, owner B at edge 15
    key_n = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      if (i <= 10)      step_a("press_wait");
      else if (i <= 14) step_blank(1'b0, "press_blank");
      else              step_b("press_owner_b");
      if (i == 12) key_n = 1'b1;
    end
    for (int i = 0; i < 20; i++) step_b("release_quiet");
    cur_own = 1'b1;
`else
    // Key is ignored in this build
    key_n = 1'b0;
    for (int i = 0; i < 50; i++) step_a("key_ignored");
    key_n = 1'b1;
    cur_own = 1'b0;
`endif

    // Asynchronous reset in the middle of BLANK
    sel_sw = 1'b1;
    step_own(cur_own, "pre_rst_e1");
    step_own(cur_own, "pre_rst_e2");
    step_blank(cur_own, "pre_rst_blank");
    step_blank(cur_own, "pre_rst_blank");
    #3;
    rst_n = 1'b0;
    #1;
    push_exp(10'h000, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b1);
    check_out("rst_mid_blank");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step_blank(1'b0, "rst1_blank");
    step_b("rst1_owner_b");
    step_b("rst1_hold");

    // Asynchronous reset while owning B
    #3;
    rst_n = 1'b0;
    #1;
    push_exp(10'h000, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b1);
    check_out("rst_mid_own_b");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step_blank(1'b0, "rst2_blank");
    step_b("rst2_owner_b");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
